// File: rtl/dtw_core_feeder.sv
// Sequencer for one dtw_core_datapath: resets and primes the core, streams
// query samples and reference memory words in lockstep, then holds the
// core's minimum and position on a valid/ready result port.
module dtw_core_feeder #(
  parameter int unsigned width    = 16,
  parameter int unsigned SQG_SIZE = 256,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ref_len,
  output logic              busy,
  input  logic [width-1:0]  sqg_data,
  input  logic              sqg_valid,
  output logic              sqg_ready,
  output logic              ref_rd_en,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic [width-1:0]  ref_rd_data,
  output logic              core_rst,
  output logic              core_running,
  output logic [width-1:0]  core_squiggle,
  output logic [width-1:0]  core_rword,
  output logic [31:0]       core_ref_len,
  input  logic [width-1:0]  core_minval,
  input  logic [31:0]       core_position,
  input  logic              core_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [width-1:0]  res_minval,
  output logic [31:0]       res_position
);

  localparam int unsigned SQ_W = $clog2(SQG_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_PRIME,
    S_FEED,
    S_FINAL,
    S_CAPT,
    S_RESULT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SQ_W-1:0]   sqg_cnt;
  logic [31:0]       ref_cnt;
  logic              sqg_pending;
  logic              ref_pending;
  logic              beat;
  logic [32:0]       ref_nxt;

  // A beat advances the core; once the query is exhausted it never stalls.
  assign sqg_pending = sqg_cnt < SQ_W'(SQG_SIZE);
  assign ref_pending = ref_cnt < core_ref_len;
  assign ref_nxt     = {1'b0, ref_cnt} + 33'd1;
  assign beat        = (state == S_FEED) && (!sqg_pending || sqg_valid);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state core/memory/stream controls.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    sqg_ready     = 1'b0;
    ref_rd_en     = 1'b0;
    ref_addr      = '0;
    core_rst      = 1'b0;
    core_running  = 1'b0;
    core_squiggle = '0;
    core_rword    = '0;
    res_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        core_rst = 1'b1;
        if (start) state_nxt = (ref_len == 32'd0) ? S_RESULT : S_CRST;
      end
      S_CRST: begin
        core_rst  = 1'b1;
        state_nxt = S_PRIME;
      end
      S_PRIME: begin
        // Sets the core's first-stage flag and fetches reference word 0.
        core_running = 1'b1;
        ref_rd_en    = 1'b1;
        state_nxt    = S_FEED;
      end
      S_FEED: begin
        core_running  = beat;
        sqg_ready     = beat && sqg_pending;
        core_squiggle = sqg_pending ? sqg_data : '0;
        core_rword    = ref_pending ? ref_rd_data : '0;
        // Reads only on beats so the held read data stays aligned over stalls.
        if (beat && (ref_nxt < {1'b0, core_ref_len})) begin
          ref_rd_en = 1'b1;
          ref_addr  = ADDR_W'(ref_nxt);
        end
        if (beat && core_done) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        // One padding beat: done leads the core's final minimum latch.
        core_running = 1'b1;
        state_nxt    = S_CAPT;
      end
      S_CAPT: begin
        state_nxt = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        core_rst  = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, latched reference length and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sqg_cnt      <= '0;
      ref_cnt      <= '0;
      core_ref_len <= '0;
      res_minval   <= '1;
      res_position <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ref_len == 32'd0) begin
              res_minval   <= '1;
              res_position <= '0;
            end else begin
              core_ref_len <= ref_len;
            end
          end
        end
        S_CRST: begin
          sqg_cnt <= '0;
          ref_cnt <= '0;
        end
        S_FEED: begin
          if (beat) begin
            if (sqg_pending) sqg_cnt <= sqg_cnt + SQ_W'(1);
            if (ref_pending) ref_cnt <= ref_cnt + 32'd1;
          end
        end
        S_CAPT: begin
          res_minval   <= core_minval;
          res_position <= core_position;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_core_feeder.sv
// Directed bench for dtw_core_feeder with a reference memory and a small
// stand-in core that sums |query-ref| over the aligned query window.
module tb_dtw_core_feeder;

  localparam int SQG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ref_len = 32'd0;
  logic        busy;
  logic [15:0] sqg_data = 16'd0;
  logic        sqg_valid = 1'b0;
  logic        sqg_ready;
  logic        ref_rd_en;
  logic [7:0]  ref_addr;
  logic [15:0] ref_rd_data = 16'd0;
  logic        core_rst;
  logic        core_running;
  logic [15:0] core_squiggle;
  logic [15:0] core_rword;
  logic [31:0] core_ref_len;
  logic [15:0] core_minval;
  logic [31:0] core_position;
  logic        core_done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_minval;
  logic [31:0] res_position;

  dtw_core_feeder #(.width(16), .SQG_SIZE(SQG), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(ref_len), .busy(busy),
    .sqg_data(sqg_data), .sqg_valid(sqg_valid), .sqg_ready(sqg_ready),
    .ref_rd_en(ref_rd_en), .ref_addr(ref_addr), .ref_rd_data(ref_rd_data),
    .core_rst(core_rst), .core_running(core_running),
    .core_squiggle(core_squiggle), .core_rword(core_rword),
    .core_ref_len(core_ref_len), .core_minval(core_minval),
    .core_position(core_position), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_minval(res_minval), .res_position(res_position)
  );

  always #5 clk = ~clk;

  // Synchronous reference memory.
  logic [15:0] ref_mem [0:255];
  always @(posedge clk) if (ref_rd_en) ref_rd_data <= ref_mem[ref_addr];

  // Stand-in core: counts running cycles since reset, done after PRIME+SQG+L-1 beats.
  logic [31:0] run_cnt = 32'd0;
  logic [15:0] acc = 16'd0;
  logic [31:0] pos = 32'd0;
  logic [15:0] cap_sq [0:31];
  logic [15:0] cap_rw [0:31];

  function automatic logic [15:0] absdiff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      run_cnt <= 32'd0;
      acc     <= 16'd0;
      pos     <= 32'd0;
    end else if (core_running) begin
      run_cnt <= run_cnt + 32'd1;
      if (run_cnt >= 32'd1 && run_cnt <= 32'd32) begin
        cap_sq[5'(run_cnt - 32'd1)] <= core_squiggle;
        cap_rw[5'(run_cnt - 32'd1)] <= core_rword;
      end
      if (run_cnt >= 32'd1 && run_cnt <= 32'(SQG))
        acc <= acc + absdiff(core_squiggle, core_rword);
      if (run_cnt >= 32'd1 && core_rword != 16'd0) pos <= pos + 32'd1;
    end
  end
  assign core_done     = !core_rst && (run_cnt >= 32'(SQG) + core_ref_len);
  assign core_minval   = acc;
  assign core_position = pos;

  // Activity counters for running cycles and core_rst rising edges.
  int   tot_run = 0;
  int   rises = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    if (core_running) tot_run <= tot_run + 1;
    rst_q <= core_rst;
    if (core_rst && !rst_q) rises <= rises + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q [0:3];
  int  cyc, run_delta, gap_viol, busy_viol, extra_ready;
  bit  timed_out;

  task automatic load_ref(input logic [15:0] a, b, c, d, e, f);
    ref_mem[0] = a; ref_mem[1] = b; ref_mem[2] = c;
    ref_mem[3] = d; ref_mem[4] = e; ref_mem[5] = f;
    for (int i = 6; i < 256; i++) ref_mem[i] = 16'h7777;
  endtask

  // Pulses start, sources the query (optional gap, optional start pokes), stops at res_valid.
  task automatic run_query(input int len, input int gap_at, input int gap_len, input bit poke);
    int qi = 0;
    int gap_left = gap_len;
    int n = 0;
    int run0;
    bit in_gap;
    @(negedge clk);
    run0 = tot_run;
    start = 1'b1; ref_len = 32'(len); sqg_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    timed_out = 0; gap_viol = 0; busy_viol = 0; extra_ready = 0; cyc = 1;
    while (!res_valid) begin
      if (n > 200) begin timed_out = 1; break; end
      in_gap = 0;
      if (qi < SQG && qi == gap_at && gap_left > 0) begin
        sqg_valid = 1'b0; gap_left--; in_gap = 1;
      end else if (qi < SQG) begin
        sqg_valid = 1'b1; sqg_data = q[qi];
      end else begin
        sqg_valid = 1'b1; sqg_data = 16'hBEEF;
      end
      start = (poke && qi >= 1);
      #1;
      if (in_gap && (core_running || ref_rd_en)) gap_viol++;
      if (!busy) busy_viol++;
      if (sqg_ready && qi < SQG) qi++;
      else if (sqg_ready) extra_ready++;
      @(negedge clk);
      n++; cyc++;
    end
    start = 1'b0;
    sqg_valid = 1'b0;
    run_delta = tot_run - run0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, sqg_ready, ref_rd_en, core_rst, core_running, res_valid} !== 6'b000100) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000100",
               {busy, sqg_ready, ref_rd_en, core_rst, core_running, res_valid});
    end
    n_vec++;
    if ({ref_addr, core_squiggle, core_rword, core_ref_len} !== 72'd0) begin
      n_err++;
      $display("FAIL reset_data: addr %0d sq %0d rw %0d len %0d expected all 0",
               ref_addr, core_squiggle, core_rword, core_ref_len);
    end
    n_vec++;
    if (res_minval !== 16'hFFFF || res_position !== 32'd0) begin
      n_err++;
      $display("FAIL reset_res: got %h/%0d expected ffff/0", res_minval, res_position);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int bad = 0;
    load_ref(1, 2, 3, 4, 9, 9);
    run_query(6, -1, 0, 0);
    n_vec++;
    if (timed_out) begin n_err++; $display("FAIL basic_timeout: got no res_valid expected res_valid"); end
    n_vec++;
    if (res_minval !== 16'd0 || res_position !== 32'd6) begin
      n_err++;
      $display("FAIL basic_result: got %0d/%0d expected 0/6", res_minval, res_position);
    end
    n_vec++;
    if (run_delta !== 12) begin n_err++; $display("FAIL basic_running: got %0d expected 12", run_delta); end
    n_vec++;
    if (cyc !== 15) begin n_err++; $display("FAIL basic_latency: got %0d expected 15", cyc); end
    n_vec++;
    if (extra_ready !== 0) begin n_err++; $display("FAIL basic_overconsume: got %0d expected 0", extra_ready); end
    // Streamed pairs: query 1..4 then zeros, reference 1,2,3,4,9,9 then zeros.
    for (int i = 0; i < 11; i++) begin
      if (cap_sq[i] !== ((i < 4) ? 16'(i + 1) : 16'd0)) bad++;
      if (cap_rw[i] !== ((i < 6) ? ref_mem[i] : 16'd0)) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL basic_stream: got %0d bad words expected 0", bad); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || res_minval !== 16'd0 || res_position !== 32'd6) begin
      n_err++;
      $display("FAIL basic_hold: got valid %b min %0d pos %0d expected 1/0/6", res_valid, res_minval, res_position);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: got valid %b busy %b expected 0/0", res_valid, busy);
    end
  endtask

  task automatic test_stall;
    run_query(6, 2, 3, 0);
    n_vec++;
    if (timed_out || res_minval !== 16'd0 || res_position !== 32'd6) begin
      n_err++;
      $display("FAIL stall_result: got %0d/%0d timeout %0d expected 0/6", res_minval, res_position, timed_out);
    end
    n_vec++;
    if (gap_viol !== 0) begin n_err++; $display("FAIL stall_frozen: got %0d active gap cycles expected 0", gap_viol); end
    n_vec++;
    if (run_delta !== 12) begin n_err++; $display("FAIL stall_running: got %0d expected 12", run_delta); end
    n_vec++;
    if (cyc !== 18) begin n_err++; $display("FAIL stall_latency: got %0d expected 18", cyc); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_zero_len;
    run_query(0, -1, 0, 0);
    n_vec++;
    if (cyc !== 1) begin n_err++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
    n_vec++;
    if (res_minval !== 16'hFFFF || res_position !== 32'd0) begin
      n_err++;
      $display("FAIL zero_result: got %h/%0d expected ffff/0", res_minval, res_position);
    end
    n_vec++;
    if (run_delta !== 0) begin n_err++; $display("FAIL zero_running: got %0d expected 0", run_delta); end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    int qi = 0;
    int n = 0;
    @(negedge clk);
    start = 1'b1; ref_len = 32'd6;
    @(negedge clk);
    start = 1'b0;
    while (qi < 2 && n < 50) begin
      sqg_valid = 1'b1; sqg_data = q[qi];
      #1;
      if (sqg_ready) qi++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (qi !== 2) begin n_err++; $display("FAIL midrst_feed: got %0d samples expected 2", qi); end
    sqg_valid = 1'b1; sqg_data = q[2];
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, sqg_ready, ref_rd_en, core_rst, core_running, res_valid} !== 6'b000100) begin
      n_err++;
      $display("FAIL midrst_ctrl: got %b expected 000100",
               {busy, sqg_ready, ref_rd_en, core_rst, core_running, res_valid});
    end
    n_vec++;
    if ({ref_addr, core_squiggle, core_rword, core_ref_len} !== 72'd0 ||
        res_minval !== 16'hFFFF || res_position !== 32'd0) begin
      n_err++;
      $display("FAIL midrst_data: len %0d sq %0d rw %0d min %h expected 0/0/0/ffff",
               core_ref_len, core_squiggle, core_rword, res_minval);
    end
    rst = 1'b0;
    sqg_valid = 1'b0;
    run_query(6, -1, 0, 0);
    n_vec++;
    if (timed_out || res_minval !== 16'd0 || res_position !== 32'd6 || run_delta !== 12) begin
      n_err++;
      $display("FAIL midrst_rerun: got %0d/%0d run %0d expected 0/6 run 12", res_minval, res_position, run_delta);
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int r0 = rises;
    res_ready = 1'b1;
    run_query(6, -1, 0, 0);
    n_vec++;
    if (timed_out || res_minval !== 16'd0 || res_position !== 32'd6) begin
      n_err++;
      $display("FAIL b2b_first: got %0d/%0d expected 0/6", res_minval, res_position);
    end
    load_ref(5, 5, 5, 5, 5, 5);
    run_query(6, -1, 0, 0);
    n_vec++;
    if (timed_out || res_minval !== 16'd10 || res_position !== 32'd6) begin
      n_err++;
      $display("FAIL b2b_second: got %0d/%0d expected 10/6", res_minval, res_position);
    end
    @(negedge clk);
    res_ready = 1'b0;
    n_vec++;
    if (rises - r0 !== 2) begin n_err++; $display("FAIL b2b_core_rst: got %0d pulses expected 2", rises - r0); end
  endtask

  task automatic test_start_ignored;
    load_ref(1, 2, 3, 4, 9, 9);
    run_query(6, -1, 0, 1);
    n_vec++;
    if (timed_out || res_minval !== 16'd0 || res_position !== 32'd6 || run_delta !== 12) begin
      n_err++;
      $display("FAIL ign_result: got %0d/%0d run %0d expected 0/6 run 12", res_minval, res_position, run_delta);
    end
    n_vec++;
    if (busy_viol !== 0 || cyc !== 15) begin
      n_err++;
      $display("FAIL ign_busy: got %0d idle cycles latency %0d expected 0/15", busy_viol, cyc);
    end
    start = 1'b1; ref_len = 32'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || res_minval !== 16'd0) begin
      n_err++;
      $display("FAIL ign_in_result: got valid %b busy %b min %0d expected 1/1/0", res_valid, busy, res_minval);
    end
    start = 1'b0;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ign_single: got valid %b busy %b expected 0/0", res_valid, busy);
    end
  endtask

  initial begin
    q[0] = 16'd1; q[1] = 16'd2; q[2] = 16'd3; q[3] = 16'd4;
    load_ref(1, 2, 3, 4, 9, 9);
    test_reset;
    test_basic;
    test_stall;
    test_zero_len;
    test_mid_reset;
    test_back_to_back;
    test_start_ignored;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dtw_core_feeder.md
Name: dtw_core_feeder

Overview:
Sequencer that drives one dtw_core_datapath instance for a single query. It accepts SQG_SIZE query samples on a valid/ready stream and streams reference samples from a synchronous reference memory. It handles core reset, priming, stalls and draining, then returns minval/position on a valid/ready result port. It sits between the query DMA/stream fabric and the DTW core.

Parameters:
width, 16, sample width (must match the core)
SQG_SIZE, 256, query length in samples (must match the core)
ADDR_W, 20, reference memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a query when in IDLE, ignored otherwise
ref_len  in  32  reference length; sampled on accepted start
busy  out  1  high in every state except IDLE
sqg_data  in  width  query sample
sqg_valid  in  1  query sample valid
sqg_ready  out  1  query sample consumed this cycle
ref_rd_en  out  1  reference memory read strobe
ref_addr  out  ADDR_W  reference memory address
ref_rd_data  in  width  read data; valid the cycle after ref_rd_en, held while ref_rd_en is low
core_rst  out  1  core synchronous reset
core_running  out  1  core run enable
core_squiggle  out  width  to core Input_squiggle
core_rword  out  width  to core Rword
core_ref_len  out  32  latched ref_len, to the core
core_minval  in  width  from core
core_position  in  32  from core
core_done  in  1  from core
res_valid  out  1  result available
res_ready  in  1  result accepted
res_minval  out  width  latched minimum
res_position  out  32  latched position

Behaviour:
- Reset values: busy=0, sqg_ready=0, ref_rd_en=0, ref_addr=0, core_rst=1, core_running=0, core_squiggle=0, core_rword=0, core_ref_len=0, res_valid=0, res_minval=all-ones, res_position=0. State=IDLE. Counters sqg_cnt and ref_cnt are 0.
- In IDLE, core_rst is held at 1.
- IDLE: on start with ref_len==0, latch res_minval=all-ones and res_position=0, then go to RESULT. On start otherwise, latch ref_len into core_ref_len and go to CRST.
- CRST (1 cycle): core_rst=1. Clear sqg_cnt and ref_cnt. Go to PRIME.
- PRIME (1 cycle): core_rst=0 and core_running=1. This sets the core's internal first-stage flag; the core captures no data in this cycle. Drive ref_rd_en=1 with ref_addr=0. Go to FEED.
- FEED: a beat occurs when (sqg_cnt<SQG_SIZE && sqg_valid) or sqg_cnt>=SQG_SIZE. Per cycle:
  - core_running=beat. With no beat, the core is frozen and nothing advances (stall).
  - sqg_ready=beat && sqg_cnt<SQG_SIZE.
  - core_squiggle = sqg_data while sqg_cnt<SQG_SIZE, else 0.
  - core_rword = ref_rd_data while ref_cnt<ref_len, else 0 (padding).
  - On a beat: sqg_cnt saturates at SQG_SIZE and ref_cnt saturates at ref_len. If ref_cnt+1<ref_len, issue ref_rd_en with ref_addr=ref_cnt+1; otherwise ref_rd_en=0.
  - ref_rd_en is never asserted on a non-beat cycle, so ref_rd_data stays aligned across stalls.
  - When core_done is 1 at a beat, go to FINAL instead of continuing.
- FINAL (1 cycle): core_running=1 with padding data. The core latches Minval on this edge, because done rises one beat before the final latch. Go to CAPT.
- CAPT (1 cycle): core_running=0. Latch res_minval=core_minval and res_position=core_position. Go to RESULT.
- RESULT: res_valid=1 and res outputs held stable. On res_ready go to IDLE; res_valid drops the next cycle. start is ignored in this state.
- Width rules: ref_addr is the low ADDR_W bits of ref_cnt. ref_len above 2^ADDR_W is not supported: the address wraps, with no error flag.
- sqg_data arriving after SQG_SIZE samples is not consumed (sqg_ready=0).
- rst mid-query: all outputs return to reset values in the next cycle. core_rst=1 clears the core. An in-flight result is dropped.
- Total core_running cycles for ref_len=L ≥ 1 with no stalls: 1 (PRIME) + SQG_SIZE + L + 1 (FINAL).

Test Plan:
1. SQG_SIZE=4, ref_len=6, query 1,2,3,4, reference 1,2,3,4,9,9, no stalls -> res_minval=0, res_position=6, exactly 12 core_running cycles, res_valid held until res_ready.
2. Same as test 1 with sqg_valid low for 3 cycles between samples 2 and 3 -> core_running and ref_rd_en low during the gap; result identical to test 1; 12 running cycles total.
3. start with ref_len=0 -> no core_running cycles; RESULT reached 1 cycle after start with res_minval=16'hFFFF and res_position=0.
4. rst asserted in FEED after 2 query samples -> next cycle all outputs at reset values. A new start with test 1 data -> result matches test 1.
5. Back-to-back queries with res_ready tied high; second query has reference 5,5,5,5,5,5 -> second res_minval=|1-5|+… core value, and it differs from the first result, showing no state leaks between queries; core_rst pulses once per query.
6. start asserted during FEED and RESULT -> ignored; busy=1 throughout; only one result is produced.
